// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped programmable interval timer.
// A 16-byte register window holds CTRL, COUNT, COMPARE and STATUS.
// A prescaled 32-bit up-counter raises a sticky MATCH flag and a one-cycle
// interrupt pulse when it equals COMPARE.
module mmio_timer #(
    parameter logic [31:0] BASE_AD    = 32'h1180_0000,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MMIO_EN,
    input  logic        MMIO_WE,
    input  logic [29:0] MMIO_WADDR,
    input  logic [3:0]  MMIO_BE,
    input  logic [31:0] MMIO_DIN,
    output logic [31:0] MMIO_DOUT,
    output logic        INTR
);

    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_COUNT   = 2'd1,
        REG_COMPARE = 2'd2,
        REG_STATUS  = 2'd3
    } reg_sel_e;

    // Implemented CTRL bits: EN, AUTO_RELOAD, IRQ_EN and the PRESCALE field.
    localparam logic [31:0] CTRL_MASK =
        32'h0000_0007 | (((32'h1 << PRESCALE_W) - 32'h1) << 8);

    logic [31:0]           ctrl_q,    ctrl_d;
    logic [31:0]           count_q,   count_d;
    logic [31:0]           compare_q, compare_d;
    logic                  match_q,   match_d;
    logic [PRESCALE_W-1:0] pcnt_q,    pcnt_d;
    logic                  intr_q,    intr_d;
    logic [31:0]           dout_q,    dout_d;

    // Bus decode
    logic        hit;
    logic        wr;
    logic        rd;
    reg_sel_e    sel;
    logic [31:0] be_mask;
    logic [31:0] rdata;

    assign hit     = (MMIO_WADDR[29:2] == BASE_AD[31:4]);
    assign sel     = reg_sel_e'(MMIO_WADDR[1:0]);
    assign wr      = MMIO_EN & MMIO_WE & hit;
    assign rd      = MMIO_EN & ~MMIO_WE & hit;
    assign be_mask = {{8{MMIO_BE[3]}}, {8{MMIO_BE[2]}}, {8{MMIO_BE[1]}}, {8{MMIO_BE[0]}}};

    // CTRL fields
    logic                  ctrl_en;
    logic                  ctrl_auto;
    logic                  ctrl_irq_en;
    logic [PRESCALE_W-1:0] ctrl_prescale;

    assign ctrl_en       = ctrl_q[0];
    assign ctrl_auto     = ctrl_q[1];
    assign ctrl_irq_en   = ctrl_q[2];
    assign ctrl_prescale = ctrl_q[8 +: PRESCALE_W];

    // Timer events. A bus write to COUNT pre-empts the tick entirely, so no
    // match is evaluated in that cycle. COMPARE is compared as currently held,
    // so a same-cycle COMPARE write only affects later ticks.
    logic tick;
    logic count_wr;
    logic match;

    assign tick     = ctrl_en & (pcnt_q == ctrl_prescale);
    assign count_wr = wr & (sel == REG_COUNT);
    assign match    = tick & ~count_wr & (count_q == compare_q);

    // Read data mux for the addressed register.
    always_comb begin
        rdata = '0;
        unique case (sel)
            REG_CTRL:    rdata = ctrl_q;
            REG_COUNT:   rdata = count_q;
            REG_COMPARE: rdata = compare_q;
            REG_STATUS:  rdata = {31'b0, match_q};
        endcase
    end

    // Next-state logic for registers, prescaler, interrupt and read data.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path can
        // leave it unassigned and infer a latch.
        ctrl_d    = ctrl_q;
        count_d   = count_q;
        compare_d = compare_q;
        match_d   = match_q;
        pcnt_d    = pcnt_q;
        intr_d    = 1'b0;
        dout_d    = dout_q;

        if (wr && sel == REG_CTRL) begin
            ctrl_d = ((ctrl_q & ~be_mask) | (MMIO_DIN & be_mask)) & CTRL_MASK;
        end
        if (wr && sel == REG_COMPARE) begin
            compare_d = (compare_q & ~be_mask) | (MMIO_DIN & be_mask);
        end

        // Prescaler: cleared by any CTRL write, parked at 0 while disabled.
        if ((wr && sel == REG_CTRL) || !ctrl_en || tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + PRESCALE_W'(1);
        end

        if (count_wr) begin
            count_d = (count_q & ~be_mask) | (MMIO_DIN & be_mask);
        end else if (tick) begin
            count_d = (match && ctrl_auto) ? 32'd0 : count_q + 32'd1;
        end

        // Set has priority over a same-cycle write-1-to-clear.
        if (match) begin
            match_d = 1'b1;
        end else if (wr && sel == REG_STATUS && MMIO_BE[0] && MMIO_DIN[0]) begin
            match_d = 1'b0;
        end

        intr_d = match & ctrl_irq_en;

        if (rd) begin
            dout_d = rdata;
        end
    end

    // State registers with synchronous reset; reset also drops a pending pulse.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers
        // update together from values sampled before the edge.
        if (RST) begin
            ctrl_q    <= '0;
            count_q   <= '0;
            compare_q <= '0;
            match_q   <= 1'b0;
            pcnt_q    <= '0;
            intr_q    <= 1'b0;
            dout_q    <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            match_q   <= match_d;
            pcnt_q    <= pcnt_d;
            intr_q    <= intr_d;
            dout_q    <= dout_d;
        end
    end

    assign MMIO_DOUT = dout_q;
    assign INTR      = intr_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: a vector table, directed multi-cycle
// sequences and a randomized run against a behavioural reference model.
module tb_mmio_timer;

    localparam logic [31:0] BASE_AD = 32'h1180_0000;
    localparam int unsigned PW      = 8;

    logic        clk;
    logic        rst;
    logic        mmio_en;
    logic        mmio_we;
    logic [29:0] mmio_waddr;
    logic [3:0]  mmio_be;
    logic [31:0] mmio_din;
    logic [31:0] mmio_dout;
    logic        intr;

    int checks = 0;
    int errors = 0;

    logic [29:0] base_w;

    mmio_timer #(
        .BASE_AD    (BASE_AD),
        .PRESCALE_W (PW)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .MMIO_EN    (mmio_en),
        .MMIO_WE    (mmio_we),
        .MMIO_WADDR (mmio_waddr),
        .MMIO_BE    (mmio_be),
        .MMIO_DIN   (mmio_din),
        .MMIO_DOUT  (mmio_dout),
        .INTR       (intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Reference model: register values after each clock edge.
    // ------------------------------------------------------------------
    logic [31:0] m_ctrl, m_count, m_compare, m_dout;
    logic        m_match, m_intr;
    int unsigned m_pcnt;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
        end
        return res;
    endfunction

    task automatic model_step(input logic r, input logic e, input logic w,
                              input logic [29:0] a, input logic [3:0] b,
                              input logic [31:0] d);
        bit          hit, wr, rd, running, tick, cnt_wr, matched, w1c, auto_rl;
        int unsigned off, ps;
        logic [31:0] rdata, n_ctrl, n_count, n_compare;
        if (r) begin
            m_ctrl = 0; m_count = 0; m_compare = 0; m_dout = 0;
            m_match = 0; m_intr = 0; m_pcnt = 0;
        end else begin
            hit     = (a[29:2] == base_w[29:2]);
            wr      = e && w && hit;
            rd      = e && !w && hit;
            off     = int'(a[1:0]);
            running = m_ctrl[0];
            auto_rl = m_ctrl[1];
            ps      = (m_ctrl >> 8) & ((1 << PW) - 1);
            tick    = running && (m_pcnt == ps);
            cnt_wr  = wr && off == 1;
            matched = tick && !cnt_wr && (m_count == m_compare);
            w1c     = wr && off == 3 && b[0] && d[0];
            case (off)
                0: rdata = m_ctrl;
                1: rdata = m_count;
                2: rdata = m_compare;
                default: rdata = {31'b0, m_match};
            endcase
            n_ctrl    = (wr && off == 0) ? (lane_merge(m_ctrl, d, b) & 32'h0000_FF07) : m_ctrl;
            n_compare = (wr && off == 2) ? lane_merge(m_compare, d, b) : m_compare;
            if (cnt_wr)       n_count = lane_merge(m_count, d, b);
            else if (matched) n_count = auto_rl ? 32'd0 : m_count + 32'd1;
            else if (tick)    n_count = m_count + 32'd1;
            else              n_count = m_count;
            if ((wr && off == 0) || !running || tick) m_pcnt = 0;
            else                                      m_pcnt = m_pcnt + 1;
            m_intr = matched && m_ctrl[2];
            if (matched)  m_match = 1'b1;
            else if (w1c) m_match = 1'b0;
            if (rd) m_dout = rdata;
            m_ctrl    = n_ctrl;
            m_count   = n_count;
            m_compare = n_compare;
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers: drive on the falling edge, sample 1 after rising.
    // ------------------------------------------------------------------
    task automatic drive(input logic r, input logic e, input logic w,
                         input logic [29:0] a, input logic [3:0] b,
                         input logic [31:0] d);
        @(negedge clk);
        rst = r; mmio_en = e; mmio_we = w; mmio_waddr = a; mmio_be = b; mmio_din = d;
        model_step(r, e, w, a, b, d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic bus_wr(input int unsigned off, input logic [3:0] b, input logic [31:0] d);
        drive(1'b0, 1'b1, 1'b1, base_w + 30'(off), b, d);
    endtask

    task automatic bus_rd(input int unsigned off);
        drive(1'b0, 1'b1, 1'b0, base_w + 30'(off), 4'h0, 32'h0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Vector table: one bus access per row, expected MMIO_DOUT after it.
    // ------------------------------------------------------------------
    typedef struct {
        logic        we;
        logic [1:0]  off;
        logic [3:0]  be;
        logic [31:0] din;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{1'b0, 2'd0, 4'h0, 32'h0000_0000, 32'h0000_0000};
        vecs[1]  = '{1'b0, 2'd1, 4'h0, 32'h0000_0000, 32'h0000_0000};
        vecs[2]  = '{1'b0, 2'd2, 4'h0, 32'h0000_0000, 32'h0000_0000};
        vecs[3]  = '{1'b0, 2'd3, 4'h0, 32'h0000_0000, 32'h0000_0000};
        vecs[4]  = '{1'b1, 2'd2, 4'h5, 32'hAABB_CCDD, 32'h0000_0000};
        vecs[5]  = '{1'b0, 2'd2, 4'h0, 32'h0000_0000, 32'h00BB_00DD};
        vecs[6]  = '{1'b1, 2'd0, 4'hF, 32'hFFFF_FFF8, 32'h00BB_00DD};
        vecs[7]  = '{1'b0, 2'd0, 4'h0, 32'h0000_0000, 32'h0000_FF00};
        vecs[8]  = '{1'b1, 2'd0, 4'hF, 32'h0000_0000, 32'h0000_FF00};
        vecs[9]  = '{1'b0, 2'd0, 4'h0, 32'h0000_0000, 32'h0000_0000};
        vecs[10] = '{1'b1, 2'd1, 4'hF, 32'h1234_5678, 32'h0000_0000};
        vecs[11] = '{1'b0, 2'd1, 4'h0, 32'h0000_0000, 32'h1234_5678};
        vecs[12] = '{1'b1, 2'd1, 4'h1, 32'hFFFF_FF99, 32'h1234_5678};
        vecs[13] = '{1'b0, 2'd1, 4'h0, 32'h0000_0000, 32'h1234_5699};
        vecs[14] = '{1'b1, 2'd3, 4'hF, 32'hFFFF_FFFF, 32'h1234_5699};
        vecs[15] = '{1'b0, 2'd3, 4'h0, 32'h0000_0000, 32'h0000_0000};

        base_w     = BASE_AD[31:2];
        rst        = 1'b1;
        mmio_en    = 1'b0;
        mmio_we    = 1'b0;
        mmio_waddr = '0;
        mmio_be    = '0;
        mmio_din   = '0;

        // Reset state and table-driven register accesses.
        do_reset(2);
        check("reset_dout", mmio_dout, 32'h0);
        check("reset_intr", 32'(intr), 32'h0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, vecs[i].we, base_w + 30'(vecs[i].off), vecs[i].be, vecs[i].din);
            check($sformatf("vec%0d_dout", i), mmio_dout, vecs[i].exp_dout);
            check($sformatf("vec%0d_intr", i), 32'(intr), 32'h0);
        end

        // Prescaled auto-reload count with interrupts every 12 cycles.
        do_reset(2);
        bus_wr(2, 4'hF, 32'd3);
        bus_wr(0, 4'hF, 32'h0000_0207);
        for (int k = 1; k <= 26; k++) begin
            bus_rd(1);
            check($sformatf("presc_count_k%0d", k), mmio_dout, 32'(((k - 1) / 3) % 4));
            check($sformatf("presc_intr_k%0d", k), 32'(intr), 32'((k % 12) == 0));
        end
        bus_rd(3);
        check("presc_status", mmio_dout, 32'h1);

        // Non-reload count across the 32-bit wrap, IRQ disabled.
        do_reset(2);
        bus_wr(1, 4'hF, 32'hFFFF_FFFE);
        bus_wr(2, 4'hF, 32'd5);
        bus_wr(0, 4'hF, 32'h0000_0001);
        bus_rd(1); check("wrap_count_k1", mmio_dout, 32'hFFFF_FFFE);
        bus_rd(1); check("wrap_count_k2", mmio_dout, 32'hFFFF_FFFF);
        bus_rd(1); check("wrap_count_k3", mmio_dout, 32'h0000_0000);
        for (int k = 4; k <= 12; k++) begin
            bus_rd(3);
            check($sformatf("wrap_status_k%0d", k), mmio_dout, 32'(k >= 9));
            check($sformatf("wrap_intr_k%0d", k), 32'(intr), 32'h0);
        end

        // Collisions: COUNT write on a tick, W1C on a match cycle.
        do_reset(2);
        bus_wr(2, 4'hF, 32'h12);
        bus_wr(0, 4'hF, 32'h1);
        bus_wr(1, 4'hF, 32'h10);
        bus_rd(1);
        check("coll_count_write_wins", mmio_dout, 32'h10);
        idle();
        bus_wr(3, 4'h1, 32'h1);
        bus_rd(3);
        check("coll_set_beats_clear", mmio_dout, 32'h1);
        bus_wr(3, 4'h1, 32'h1);
        bus_rd(3);
        check("coll_w1c_clears", mmio_dout, 32'h0);

        // Reset on the cycle a match would fire, with a bus write ignored.
        do_reset(2);
        bus_wr(2, 4'hF, 32'd3);
        bus_wr(0, 4'hF, 32'h0000_0207);
        for (int k = 1; k <= 11; k++) idle();
        drive(1'b1, 1'b1, 1'b1, base_w + 30'd1, 4'hF, 32'h77);
        check("midrst_intr_a", 32'(intr), 32'h0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        idle();
        check("midrst_intr_b", 32'(intr), 32'h0);
        for (int r = 0; r < 4; r++) begin
            bus_rd(r);
            check($sformatf("midrst_reg%0d", r), mmio_dout, 32'h0);
        end

        // Out-of-window accesses leave registers and read data alone.
        bus_wr(2, 4'hF, 32'h55);
        bus_rd(2);
        check("oow_setup", mmio_dout, 32'h55);
        drive(1'b0, 1'b1, 1'b0, base_w + 30'd4, 4'h0, 32'h0);
        check("oow_read_holds", mmio_dout, 32'h55);
        drive(1'b0, 1'b1, 1'b1, base_w + 30'd4, 4'hF, 32'h0000_0207);
        drive(1'b0, 1'b1, 1'b1, base_w - 30'd4, 4'hF, 32'h0000_0207);
        bus_rd(0);
        check("oow_ctrl_untouched", mmio_dout, 32'h0);

        // Randomized traffic against the reference model.
        do_reset(2);
        for (int n = 0; n < 3000; n++) begin
            logic        r, e, w;
            logic [29:0] a;
            logic [3:0]  b;
            logic [31:0] d;
            int unsigned off;
            r   = ($urandom_range(0, 299) == 0);
            e   = ($urandom_range(0, 3) == 0);
            w   = $urandom_range(0, 1) == 1;
            off = $urandom_range(0, 3);
            a   = ($urandom_range(0, 9) < 9) ? base_w + 30'(off) : 30'($urandom);
            b   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            case (off)
                0: d = {16'($urandom), 8'($urandom_range(0, 3)), 5'($urandom), 3'($urandom)};
                1: d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                   : 32'($urandom_range(0, 12));
                2: d = 32'($urandom_range(0, 12));
                default: d = {31'($urandom), 1'($urandom_range(0, 1))};
            endcase
            drive(r, e, w, a, b, d);
            check("rand_dout", mmio_dout, m_dout);
            check("rand_intr", 32'(intr), 32'(m_intr));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped programmable interval timer on the MCU MMIO bus, alongside the LED, switch and seven-segment registers.
- Decodes MMIO writes and reads for its own 16-byte window and keeps a prescaled 32-bit up-counter.
- On a compare match it raises a sticky status flag and a one-cycle interrupt pulse, which feeds the MCU INTR input (OR'd with the debounced button).

Parameters:
- BASE_AD, 32'h11800000, byte address of register window; must be 16-byte aligned.
- PRESCALE_W, 8, width of CTRL prescale field and internal prescale counter.

Ports:
- CLK  input  1  MCU clock (sclk domain).
- RST  input  1  synchronous, active-high reset.
- MMIO_EN  input  1  bus access strobe, one cycle per access.
- MMIO_WE  input  1  1 = write, 0 = read (qualified by MMIO_EN).
- MMIO_WADDR  input  30  word address (byte address [31:2]).
- MMIO_BE  input  4  byte enables for writes.
- MMIO_DIN  input  32  write data, CPU to peripheral.
- MMIO_DOUT  output  32  registered read data, peripheral to CPU.
- INTR  output  1  one-cycle interrupt pulse.

Behaviour:
- Register map (offset from BASE_AD):
  - +0x0 CTRL: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN, [8+PRESCALE_W-1:8] PRESCALE. Other bits read 0.
  - +0x4 COUNT: read/write.
  - +0x8 COMPARE: read/write.
  - +0xC STATUS: [0] MATCH, sticky; write 1 to clear. Other bits read 0.
- Address hit: {MMIO_WADDR,2'b00}[31:4] == BASE_AD[31:4]. No hit means no register effect and MMIO_DOUT holds its value.
- Writes (MMIO_EN & MMIO_WE & hit):
  - Apply per byte lane where MMIO_BE[i]=1; lanes with BE=0 are unchanged.
  - For STATUS, only BE[0]/DIN[0] matter.
- Reads (MMIO_EN & ~MMIO_WE & hit): MMIO_DOUT is loaded on the next CLK edge, so data is valid the cycle after the access. The bus holds it until the next hit read.
- Prescaler:
  - An internal counter pcnt runs only while EN=1.
  - tick=1 when pcnt==PRESCALE; pcnt then returns to 0, otherwise it increments.
  - A tick therefore occurs every PRESCALE+1 cycles; PRESCALE=0 gives a tick every cycle.
  - Any write to CTRL clears pcnt.
  - EN=0 freezes COUNT and holds pcnt at 0.
- On tick:
  - If COUNT==COMPARE: MATCH<=1, and COUNT<=0 if AUTO_RELOAD, else COUNT<=COUNT+1.
  - Otherwise COUNT<=COUNT+1.
  - Arithmetic is 32-bit unsigned and wraps 0xFFFFFFFF -> 0 silently.
- INTR: registered; INTR=1 for exactly one cycle, the cycle after the edge on which a match occurred, when IRQ_EN=1 at that match. It does not repeat while MATCH stays set. A new match produces a new pulse even if MATCH was never cleared.
- Simultaneous events:
  - Bus write to COUNT in the same cycle as a tick: the write wins and no increment or match is evaluated.
  - W1C of MATCH in the same cycle as a new match: set wins, MATCH=1.
  - Write to COMPARE in a tick cycle: the match uses the old COMPARE.
- Reset (RST=1 at an edge, including mid-count):
  - CTRL, COUNT, COMPARE, STATUS, pcnt, MMIO_DOUT all become 0; INTR=0.
  - A pending INTR pulse is suppressed.
  - Bus accesses during RST are ignored.

Test Plan:
- Reset then read each register: RST 2 cycles, read +0x0/+0x4/+0x8/+0xC -> MMIO_DOUT=0 each, one cycle after each access; INTR stays 0.
- Byte-lane write: write 0xAABBCCDD to COMPARE with BE=4'b0101 after reset -> readback 0x00BB00DD.
- Prescaled count: COMPARE=3, CTRL=0x0000_0207 (PRESCALE=2, IRQ_EN, AUTO_RELOAD, EN) -> COUNT steps 0,1,2,3 every 3 cycles; on the tick where COUNT=3 it becomes 0 and MATCH=1; INTR is high for 1 cycle, 12 cycles after the CTRL write completes; the pattern repeats every 12 cycles.
- Non-reload wrap: COUNT=0xFFFFFFFE, COMPARE=5, CTRL=0x1 -> COUNT reaches 0xFFFFFFFF then 0x00000000, no MATCH until COUNT==5; INTR stays 0 (IRQ_EN=0) while MATCH=1.
- Collisions: write COUNT=0x10 on a tick cycle -> COUNT=0x10, not 0x11. W1C STATUS on a match cycle -> MATCH stays 1.
- Reset mid-operation plus out-of-window access: assert RST while counting -> all registers 0, no INTR. Read from BASE_AD+0x10 -> MMIO_DOUT unchanged.
